sobol_stream_arbiter: RTL and testbench
=======================================

Name: sobol_stream_arbiter

Overview:
- Shares one 1-D Sobol sequence generator among NREQ requesters that each need a unary stochastic bitstream of a binary value.
- Grants the generator round-robin, one requester at a time, and drives its enable for exactly one full period (2^INWD cycles), so the sequence always starts at 0 for every job.
- Compares the latched value against the sequence and emits one stream bit per cycle, tagged with the owner.
- Sits between the requesting SC compute units and the Sobol generator; shares clk/rst_n with the generator.

Parameters:
- INWD, 8, data width and log2 of the stream length (stream length = 2^INWD).
- NREQ, 4, number of requesters (2..16).
- LOGNREQ, 2, ceil(log2(NREQ)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester job request, level; held until that requester's done.
- value  in  NREQ*INWD  per-requester value; slice i = value[i*INWD +: INWD]; sampled at grant.
- sobolSeq  in  INWD  generator output; registered, advances one step on the edge after rngEnable=1.
- rngEnable  out  1  generator enable.
- grant  out  NREQ  one-hot current owner; all-zero when idle.
- busy  out  1  a job is in RUN or DONE.
- bitOut  out  1  stream bit.
- bitValid  out  1  bitOut is valid for the owner.
- bitOwner  out  LOGNREQ  index of the current owner.
- done  out  1  one-cycle job-complete pulse.
- syncErr  out  1  sticky phase error.

Behaviour:
- Reset (async): state IDLE; rrPtr=0; cnt=0; all outputs 0. Because the generator shares rst_n, both restart aligned. Reset mid-job aborts the job with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req is nonzero, pick the first asserted index searching upward (with wrap) from rrPtr.
  - Register grant, bitOwner and that requester's value; go to RUN.
  - Otherwise stay in IDLE with rngEnable=0.
- RUN:
  - rngEnable=1 for every RUN cycle.
  - bitOut = (latchedValue > sobolSeq), unsigned compare.
  - bitValid = req[owner] in the same cycle.
  - cnt increments each cycle; on cnt = 2^INWD-1, set cnt to 0 and go to DONE.
  - RUN lasts exactly 2^INWD cycles.
- Owner drops req mid-RUN:
  - The job is not aborted; rngEnable stays 1 until the period ends, preserving phase alignment.
  - bitValid is 0 for the rest of the job; done still pulses.
- DONE:
  - done=1, rngEnable=0, bitValid=0, grant held.
  - rrPtr = owner+1 (wrap at NREQ).
  - Next state IDLE, where grant is cleared.
- Requester rule: deassert req at the edge ending the DONE cycle. A req still high in IDLE is treated as a new job.
- Latency: req seen in IDLE cycle t gives grant and first bitValid at t+1, last bit at t+2^INWD, done at t+2^INWD+1, IDLE at t+2^INWD+2. Back-to-back jobs have 2 cycles overhead.
- Stream property: sobolSeq visits each of 0..2^INWD-1 once per period, so a complete job has exactly value ones.
- Phase check: in the first RUN cycle, if sobolSeq != 0, set syncErr=1 (sticky until reset). The job proceeds normally.
- value changing after grant has no effect on the current job.
- Simultaneous requests: only one grant; the others wait in order from rrPtr.
- rngEnable is never 1 outside RUN.

Test Plan:
- INWD=8, req=0001, value[0]=128 → grant=0001 one cycle later; first bits 1,0,1,0 (sobolSeq 0,128,64,192); 128 ones over 256 valid cycles; done pulse at cycle 257 after req; syncErr=0.
- value=0 and value=255 on requesters 1 and 2, both requesting together → requester 1 served first (rrPtr=0, so index 1 is the first asserted found) with 0 ones. Requester 2 served next with 255 ones. rrPtr=3 afterwards. 2-cycle gap between jobs.
- req=1111 held continuously, each dropped at its done → grant order 0,1,2,3,0; no requester is granted twice in a row while another is waiting.
- Owner drops req at bit 10 → bitValid=0 from that cycle; rngEnable stays 1 to cycle 256; done pulses. The next job's first sobolSeq is 0 and syncErr stays 0.
- Assert rst_n=0 at RUN bit 100 → all outputs 0 immediately, no done pulse. A new job after release starts from sobolSeq=0.
- Force the generator one step out of phase (enable it externally for 1 cycle while IDLE) → syncErr=1 in the first RUN cycle and stays 1 until reset.

Source files
------------

// File: rtl/sobol_stream_arbiter.sv
// -----------------------------------------------------------------------------
// sobol_stream_arbiter
//
// Shares one 1-D Sobol sequence generator among NREQ requesters. Each job is
// granted round-robin and owns the generator for exactly one full period
// (2^INWD cycles). Because the generator is only enabled during RUN and every
// job runs a whole period, the sequence returns to 0 at the start of each job.
// During RUN the latched value is compared against the sequence to produce
// one unary stochastic bit per cycle, tagged with the owner index.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset (shared with the generator)
//   req        per-requester level request, held until that requester's done
//   value      per-requester value, slice i = value[i*INWD +: INWD]
//   sobolSeq   generator output (registered, steps on the edge after rngEnable)
//   rngEnable  generator enable, high for every RUN cycle only
//   grant      one-hot current owner, zero when idle
//   busy       a job is in RUN or DONE
//   bitOut     stream bit: latched value > sobolSeq
//   bitValid   bitOut is valid for the owner
//   bitOwner   index of the current owner
//   done       one-cycle job-complete pulse
//   syncErr    sticky flag: generator was not at 0 in a job's first RUN cycle
// -----------------------------------------------------------------------------
module sobol_stream_arbiter #(
    parameter int unsigned INWD    = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LOGNREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*INWD-1:0] value,
    input  logic [INWD-1:0]      sobolSeq,
    output logic                 rngEnable,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 bitOut,
    output logic                 bitValid,
    output logic [LOGNREQ-1:0]   bitOwner,
    output logic                 done,
    output logic                 syncErr
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              state_q;
    logic [LOGNREQ-1:0]  rr_ptr_q;
    logic [LOGNREQ-1:0]  owner_q;
    logic [NREQ-1:0]     grant_q;
    logic [INWD-1:0]     cnt_q;
    logic [INWD-1:0]     val_q;
    logic                dropped_q;
    logic                sync_err_q;

    // Round-robin search: first asserted request at or above rr_ptr_q, wrapping.
    logic                pick_valid;
    logic [LOGNREQ-1:0]  pick_idx;
    logic [INWD-1:0]     pick_val;
    int unsigned         scan_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_val   = '0;
        scan_idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = 32'(rr_ptr_q) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = LOGNREQ'(scan_idx);
                pick_val   = value[scan_idx*INWD +: INWD];
            end
        end
    end

    logic run;
    logic first_run;
    assign run       = (state_q == StRun);
    assign first_run = run && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            val_q      <= '0;
            dropped_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q   <= StRun;
                        grant_q   <= NREQ'(1) << pick_idx;
                        owner_q   <= pick_idx;
                        val_q     <= pick_val;
                        cnt_q     <= '0;
                        dropped_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (first_run && (sobolSeq != '0)) begin
                        sync_err_q <= 1'b1;
                    end
                    // Once the owner lets go, its remaining bits are never valid,
                    // but the period still runs out to keep the generator aligned.
                    if (!req[owner_q]) begin
                        dropped_q <= 1'b1;
                    end
                    if (cnt_q == {INWD{1'b1}}) begin
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    if (owner_q == LOGNREQ'(NREQ - 1)) begin
                        rr_ptr_q <= '0;
                    end else begin
                        rr_ptr_q <= owner_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rngEnable = run;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign grant     = grant_q;
    assign bitOwner  = owner_q;
    assign bitOut    = run && (val_q > sobolSeq);
    assign bitValid  = run && req[owner_q] && !dropped_q;
    // Flag the phase error in the offending cycle itself, then hold it.
    assign syncErr   = sync_err_q || (first_run && (sobolSeq != '0));

endmodule

// File: tb/tb_sobol_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sobol_stream_arbiter
//
// Directed bench for sobol_stream_arbiter. Provides a bit-reversed-counter
// Sobol generator (0,128,64,192,...) sharing clk/rst_n, a job-level model of
// the arbiter checked on every falling edge, and literal per-test expectations.
// -----------------------------------------------------------------------------
module tb_sobol_stream_arbiter;

    localparam int INWD    = 8;
    localparam int NREQ    = 4;
    localparam int LOGNREQ = 2;
    localparam int PERIOD  = 1 << INWD;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*INWD-1:0] value;
    logic [INWD-1:0]      sobolSeq;
    logic                 rngEnable;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 bitOut;
    logic                 bitValid;
    logic [LOGNREQ-1:0]   bitOwner;
    logic                 done;
    logic                 syncErr;

    logic                 force_en;
    logic [INWD-1:0]      gen_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    sobol_stream_arbiter #(
        .INWD    (INWD),
        .NREQ    (NREQ),
        .LOGNREQ (LOGNREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .value     (value),
        .sobolSeq  (sobolSeq),
        .rngEnable (rngEnable),
        .grant     (grant),
        .busy      (busy),
        .bitOut    (bitOut),
        .bitValid  (bitValid),
        .bitOwner  (bitOwner),
        .done      (done),
        .syncErr   (syncErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator: 1-D Sobol in base 2 is the bit-reversed step count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gen_cnt <= '0;
        else if (rngEnable || force_en) gen_cnt <= gen_cnt + 1'b1;
    end
    always_comb begin
        for (int b = 0; b < INWD; b++) sobolSeq[b] = gen_cnt[INWD-1-b];
    end

    // ---------------- job-level model ----------------
    // m_phase: -1 idle, 0..PERIOD-1 stream bit index, PERIOD done cycle.
    int        m_phase = -1;
    int        m_owner = 0;
    int        m_ptr   = 0;
    int        m_val   = 0;
    bit        m_drop  = 1'b0;
    bit        m_err   = 1'b0;
    int        m_j;
    bit        m_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= -1;
            m_owner <= 0;
            m_ptr   <= 0;
            m_val   <= 0;
            m_drop  <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_phase == -1) begin
            m_found = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                m_j = (m_ptr + i) % NREQ;
                if (!m_found && req[m_j]) begin
                    m_found = 1'b1;
                    m_owner <= m_j;
                    m_val   <= int'(value[m_j*INWD +: INWD]);
                    m_phase <= 0;
                    m_drop  <= 1'b0;
                end
            end
        end else if (m_phase < PERIOD) begin
            if (m_phase == 0 && sobolSeq != 0) m_err <= 1'b1;
            if (!req[m_owner]) m_drop <= 1'b1;
            m_phase <= m_phase + 1;
        end else begin
            m_ptr   <= (m_owner + 1) % NREQ;
            m_phase <= -1;
        end
    end

    logic            e_run, e_busy, e_bit, e_valid, e_done, e_err;
    logic [NREQ-1:0] e_grant;

    always @(negedge clk) begin
        e_run   = (m_phase >= 0) && (m_phase < PERIOD);
        e_busy  = (m_phase >= 0);
        e_grant = e_busy ? NREQ'(1 << m_owner) : '0;
        e_bit   = e_run && (m_val > int'(sobolSeq));
        e_valid = e_run && req[m_owner] && !m_drop;
        e_done  = (m_phase == PERIOD);
        e_err   = m_err || (m_phase == 0 && sobolSeq != 0);
        vectors++;
        if ({rngEnable, grant, busy, bitOut, bitValid, done, syncErr} !==
            {e_run, e_grant, e_busy, e_bit, e_valid, e_done, e_err} ||
            (e_busy && int'(bitOwner) != m_owner)) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got rng=%b grant=%b busy=%b bit=%b valid=%b owner=%0d done=%b err=%b, want rng=%b grant=%b busy=%b bit=%b valid=%b owner=%0d done=%b err=%b",
                     cyc, rngEnable, grant, busy, bitOut, bitValid, bitOwner, done, syncErr,
                     e_run, e_grant, e_busy, e_bit, e_valid, m_owner, e_done, e_err);
        end
    end

    // ---------------- stream monitor ----------------
    int              grant_log[$];
    logic [NREQ-1:0] prev_grant = '0;
    int              ones = 0, vcount = 0, last_ones = 0, last_valid = 0, grant_cyc = 0;

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            ones = 0; vcount = 0; prev_grant = '0;
        end else begin
            if (grant != 0 && prev_grant == 0) begin
                grant_log.push_back(onehot_idx(grant));
                grant_cyc = cyc;
                ones = 0;
                vcount = 0;
            end
            if (bitValid) vcount++;
            if (bitValid && bitOut) ones++;
            if (done) begin
                last_ones  = ones;
                last_valid = vcount;
            end
            prev_grant = grant;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no done pulse within 600 cycles, expected one", name);
        end
    endtask

    int c, d1, d2;
    int exp_order[5] = '{3, 0, 1, 2, 3};

    initial begin
        rst_n = 1'b0; req = '0; value = '0; force_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", int'({rngEnable, grant, busy, bitOut, bitValid, done, syncErr}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(2);

        // Test 1: single requester, value 128.
        value[7:0] = 8'd128; req = 4'b0001; c = cyc;
        @(negedge clk); @(negedge clk);
        check("t1 grant", int'(grant), 1);
        check("t1 seq0", int'(sobolSeq), 0);
        check("t1 bit0", int'(bitOut), 1);
        @(negedge clk); check("t1 bit1", int'(bitOut), 0);
        @(negedge clk); check("t1 bit2", int'(bitOut), 1);
        @(negedge clk); check("t1 bit3", int'(bitOut), 0);
        wait_done("t1 done");
        check("t1 done cycle", cyc - c, 257);
        @(posedge clk); #1 req[0] = 1'b0;
        check("t1 ones", last_ones, 128);
        check("t1 valid bits", last_valid, 256);
        check("t1 syncErr", int'(syncErr), 0);
        step(2);

        // Test 2: values 0 and 255 requested together; rrPtr is 1 here.
        grant_log.delete();
        value[15:8] = 8'd0; value[23:16] = 8'd255; req = 4'b0110;
        wait_done("t2a done"); d1 = cyc;
        @(posedge clk); #1 req[1] = 1'b0;
        check("t2a ones", last_ones, 0);
        wait_done("t2b done"); d2 = cyc;
        @(posedge clk); #1 req[2] = 1'b0;
        check("t2b ones", last_ones, 255);
        check("t2 gap", grant_cyc - d1, 2);
        check("t2 jobs", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t2 first owner", grant_log[0], 1);
            check("t2 second owner", grant_log[1], 2);
        end
        step(2);

        // Test 3: all four requesting; rrPtr=3 after test 2, so 3,0,1,2,3.
        grant_log.delete();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done("t3 done");
            @(posedge clk); #1;
            if (k == 4) begin
                req = '0;
            end else begin
                req[exp_order[k]] = 1'b0;
                @(posedge clk); #1 req[exp_order[k]] = 1'b1;
            end
        end
        check("t3 jobs", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            for (int k = 0; k < 5; k++) check("t3 order", grant_log[k], exp_order[k]);
        end
        step(2);

        // Test 4: owner drops req at bit 10; next job must start in phase.
        value[7:0] = 8'd200; req = 4'b0001; c = cyc;
        repeat (11) @(posedge clk); #1 req[0] = 1'b0;
        @(negedge clk);
        check("t4 valid after drop", int'(bitValid), 0);
        check("t4 rng after drop", int'(rngEnable), 1);
        wait_done("t4 done");
        check("t4 done cycle", cyc - c, 257);
        @(posedge clk); #1;
        check("t4 valid bits", last_valid, 10);
        step(1);
        value[15:8] = 8'd50; req = 4'b0010;
        @(negedge clk); @(negedge clk);
        check("t4 next grant", int'(grant), 2);
        check("t4 next seq0", int'(sobolSeq), 0);
        check("t4 syncErr", int'(syncErr), 0);
        wait_done("t4 next done");
        @(posedge clk); #1 req = '0;
        check("t4 next ones", last_ones, 50);
        step(2);

        // Test 5: reset at RUN bit 100.
        value[15:8] = 8'd77; req = 4'b0010; c = cyc;
        repeat (101) @(posedge clk); #1 rst_n = 1'b0;
        #1 check("t5 reset outputs",
                 int'({rngEnable, grant, busy, bitOut, bitValid, done, syncErr, bitOwner}), 0);
        repeat (2) begin
            @(negedge clk); check("t5 no done in reset", int'(done), 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("t5 regrant", int'(grant), 2);
        check("t5 seq0", int'(sobolSeq), 0);
        wait_done("t5 done");
        @(posedge clk); #1 req = '0;
        check("t5 ones", last_ones, 77);
        step(2);

        // Test 6: generator stepped once while idle -> phase error.
        force_en = 1'b1; step(1); force_en = 1'b0;
        value[7:0] = 8'd10; req = 4'b0001;
        @(negedge clk);
        check("t6 err idle", int'(syncErr), 0);
        @(negedge clk);
        check("t6 seq first", int'(sobolSeq), 128);
        check("t6 err first run", int'(syncErr), 1);
        wait_done("t6 done");
        @(posedge clk); #1 req = '0;
        check("t6 ones", last_ones, 10);
        @(negedge clk);
        check("t6 err sticky", int'(syncErr), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check("t6 err cleared", int'(syncErr), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
